// File: rtl/ps2_rx_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ps2_rx_param                                             |
// | Description : Parametrised PS/2-style serial receiver. Synchronises,   |
// |               glitch-filters and edge-detects scl/sda, decodes start/  |
// |               data/parity/stop frames with a stall timeout and hands   |
// |               bytes out over valid/ready.                              |
// |               Define PS2_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO;       |
// |               otherwise a single holding register is used.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ps2_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int PARITY_ODD  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 ck,
  input  logic                 reset,
  input  logic                 scl,
  input  logic                 sda,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 busy
);

  localparam int FCW = $clog2(FILT_LEN);
  localparam int BCW = $clog2(DATA_BITS);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: index 0 = scl, index 1 = sda
  // ---------------------------------------------------------------------
  logic [1:0] w_pin;
  logic [1:0] w_filt;

  assign w_pin = {sda, scl};

  for (genvar gi = 0; gi < 2; gi++) begin : g_in
    logic           r_s1;
    logic           r_s2;
    logic           r_f;
    logic [FCW-1:0] r_cnt;

    // Two-flop synchroniser, then the output follows only a full run of FILT_LEN new samples
    always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_f   <= 1'b1;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_pin[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_f) begin
          r_cnt <= '0;
        end else if (r_cnt == FCW'(FILT_LEN - 1)) begin
          r_f   <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + FCW'(1);
        end
      end
    end

    assign w_filt[gi] = r_f;
  end

  logic r_scl_d;
  logic w_tick;
  logic w_sda;

  assign w_tick = r_scl_d & ~w_filt[0];
  assign w_sda  = w_filt[1];

  // ---------------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------------
  state_t         r_state;
  state_t         w_state_nxt;
  logic [BCW-1:0] r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic           r_par_bit;
  logic [TCW-1:0] r_tmo_cnt;
  logic           w_timeout;
  logic           w_par_ok;
  logic           w_perr_nxt;
  logic           w_ferr_nxt;
  logic           w_push;

  assign w_timeout = (r_state != S_IDLE) && !w_tick &&
                     (r_tmo_cnt == TCW'(TIMEOUT_CYC - 1));
  assign w_par_ok  = ((^{r_shift, r_par_bit}) == (PARITY_ODD != 0));

  // State register
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, frame verdict and push request; a stall overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick && !w_sda) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_tick && (r_bit_cnt == BCW'(DATA_BITS - 1))) w_state_nxt = S_PARITY;
      end
      S_PARITY: begin
        if (w_tick) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tick) begin
          w_state_nxt = S_IDLE;
          w_ferr_nxt  = !w_sda;
          w_perr_nxt  = !w_par_ok;
          w_push      = w_sda && w_par_ok;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_ferr_nxt  = 1'b1;
    end
  end

  // Shift register, bit counter, parity capture and stall counter
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_scl_d   <= 1'b1;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_scl_d <= w_filt[0];
      if (r_state == S_IDLE && w_tick && !w_sda) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end
      if (r_state == S_DATA && w_tick) begin
        r_shift[r_bit_cnt] <= w_sda;
        r_bit_cnt          <= r_bit_cnt + BCW'(1);
      end
      if (r_state == S_PARITY && w_tick) begin
        r_par_bit <= w_sda;
      end
      if (w_tick || r_state == S_IDLE || w_timeout) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TCW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------
  logic                 w_full;
  logic                 w_valid;
  logic                 w_pop;
  logic                 w_wr;
  logic [DATA_BITS-1:0] w_head;

  assign w_pop = w_valid & data_ready;
  // A full buffer still accepts a frame when the head leaves in the same cycle
  assign w_wr  = w_push && (!w_full || w_pop);

`ifdef PS2_RX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_valid = (r_count != '0);
  assign w_head  = r_mem[r_rptr];

  // FIFO storage; contents are only visible through the count-gated head
  always_ff @(posedge ck) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_vld;

  assign w_full  = r_hold_vld;
  assign w_valid = r_hold_vld;
  assign w_head  = r_hold;

  // Single holding register with the same accept/drop rules as the FIFO
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_wr) begin
      r_hold     <= r_shift;
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end
  end
`endif

  // One-cycle status pulses, registered so they appear the cycle after the deciding tick
  logic r_perr;
  logic r_ferr;
  logic r_ovf;

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_perr <= w_perr_nxt;
      r_ferr <= w_ferr_nxt;
      r_ovf  <= w_push && w_full && !w_pop;
    end
  end

  assign data_out   = w_valid ? w_head : '0;
  assign data_valid = w_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overflow   = r_ovf;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_ps2_rx_param                                          |
// | Description : Self-checking bench for ps2_rx_param with a queue-based  |
// |               reference model of the receive buffer.                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_ps2_rx_param;

  localparam int DB = 8;
  localparam int FL = 4;
  localparam int TO = 5000;
  localparam int PO = 1;
  localparam int FD = 4;
`ifdef PS2_RX_FIFO_EN
  localparam int DEPTH = FD;
`else
  localparam int DEPTH = 1;
`endif

  logic          ck = 1'b0;
  logic          reset = 1'b0;
  logic          scl = 1'b1;
  logic          sda = 1'b1;
  logic          data_ready = 1'b0;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 ck = ~ck;

  ps2_rx_param #(
    .DATA_BITS  (DB),
    .FILT_LEN   (FL),
    .TIMEOUT_CYC(TO),
    .PARITY_ODD (PO),
    .FIFO_DEPTH (FD)
  ) dut (
    .ck        (ck),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Observation: pulse counters, handshake log and event timestamps
  int            cyc = 0;
  int            n_perr = 0, n_ferr = 0, n_ovf = 0, busy_hi = 0;
  int            perr_cyc = -1, vrise_cyc = -1, fall_cyc = 0;
  logic [DB-1:0] vrise_data = '0;
  logic          prev_valid = 1'b0;
  logic [DB-1:0] popped_q[$];

  always @(negedge ck) begin
    cyc++;
    if (parity_err) begin n_perr++; perr_cyc = cyc; end
    if (frame_err)  n_ferr++;
    if (overflow)   n_ovf++;
    if (busy)       busy_hi++;
    if (data_valid && !prev_valid) begin vrise_cyc = cyc; vrise_data = data_out; end
    prev_valid = data_valid;
    if (data_valid && data_ready) popped_q.push_back(data_out);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Reference parity bit that makes the frame correct
  function automatic logic good_par(input logic [DB-1:0] d);
    return ((($countones(d) + PO) % 2) == 1);
  endfunction

  function automatic logic [15:0] mk_frame(input logic [DB-1:0] d, input logic p, input logic st);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
    f[DB+1] = p;
    f[DB+2] = st;
    return f;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    int h, l;
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(8, 14);
      l = $urandom_range(10, 14);
      sda = bits[i];
      wait_cyc(h);
      scl = 1'b0;
      fall_cyc = cyc;
      wait_cyc(l);
      scl = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic st);
    send_bits(mk_frame(d, p, st), DB + 3);
    wait_cyc(6);
    sda = 1'b1;
    wait_cyc(14);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wait_cyc(4);
    @(negedge ck);
    n_checks++; if (data_out !== '0) $display("FAIL reset_data_out: got %h want 0", data_out); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else n_pass++;
    n_checks++; if ({parity_err, frame_err, overflow} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {parity_err, frame_err, overflow}); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    @(posedge ck); #1;
    reset = 1'b1;
    wait_cyc(10);
  endtask

  task automatic test_good_frame();
    int perr0 = n_perr, ferr0 = n_ferr;
    data_ready = 1'b1;
    popped_q.delete();
    vrise_cyc = -1;
    send_frame(8'h1C, good_par(8'h1C), 1'b1);
    n_checks++; if (popped_q.size() != 1) $display("FAIL good_count: got %0d want 1", popped_q.size()); else n_pass++;
    n_checks++; if (vrise_data !== 8'h1C) $display("FAIL good_data: got %h want 1c", vrise_data); else n_pass++;
    n_checks++; if (vrise_cyc - fall_cyc != FL + 4)
      $display("FAIL good_latency: got %0d want %0d", vrise_cyc - fall_cyc, FL + 4); else n_pass++;
    n_checks++; if (n_perr - perr0 + n_ferr - ferr0 != 0)
      $display("FAIL good_no_err: got %0d want 0", n_perr - perr0 + n_ferr - ferr0); else n_pass++;
    @(negedge ck);
    n_checks++; if (data_out !== '0 || data_valid !== 1'b0)
      $display("FAIL good_empty_after_pop: got %h/%b want 0/0", data_out, data_valid); else n_pass++;
  endtask

  task automatic test_parity_err();
    int perr0 = n_perr, ferr0 = n_ferr;
    data_ready = 1'b0;
    perr_cyc = -1;
    send_frame(8'hA5, ~good_par(8'hA5), 1'b1);
    n_checks++; if (n_perr - perr0 != 1) $display("FAIL perr_count: got %0d want 1", n_perr - perr0); else n_pass++;
    n_checks++; if (n_ferr - ferr0 != 0) $display("FAIL perr_no_ferr: got %0d want 0", n_ferr - ferr0); else n_pass++;
    n_checks++; if (perr_cyc - fall_cyc != FL + 4)
      $display("FAIL perr_latency: got %0d want %0d", perr_cyc - fall_cyc, FL + 4); else n_pass++;
    @(negedge ck);
    n_checks++; if (data_valid !== 1'b0) $display("FAIL perr_valid: got %b want 0", data_valid); else n_pass++;
  endtask

  task automatic test_stop_err();
    int perr0 = n_perr, ferr0 = n_ferr;
    data_ready = 1'b1;
    popped_q.delete();
    send_frame(8'h55, good_par(8'h55), 1'b0);
    n_checks++; if (n_ferr - ferr0 != 1) $display("FAIL stop_ferr: got %0d want 1", n_ferr - ferr0); else n_pass++;
    n_checks++; if (n_perr - perr0 != 0) $display("FAIL stop_no_perr: got %0d want 0", n_perr - perr0); else n_pass++;
    n_checks++; if (popped_q.size() != 0) $display("FAIL stop_no_push: got %0d want 0", popped_q.size()); else n_pass++;
    send_frame(8'h66, good_par(8'h66), 1'b1);
    n_checks++; if (popped_q.size() != 1 || popped_q[0] !== 8'h66)
      $display("FAIL stop_next_frame: got %0d items want one 66", popped_q.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    int ferr0 = n_ferr;
    data_ready = 1'b1;
    popped_q.delete();
    send_bits(mk_frame(DB'($urandom), 1'b0, 1'b1), 5);
    sda = 1'b1;
    @(negedge ck);
    n_checks++; if (busy !== 1'b1) $display("FAIL tmo_busy_mid: got %b want 1", busy); else n_pass++;
    wait_cyc(TO + 10);
    @(negedge ck);
    n_checks++; if (n_ferr - ferr0 != 1) $display("FAIL tmo_ferr: got %0d want 1", n_ferr - ferr0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL tmo_busy_end: got %b want 0", busy); else n_pass++;
    send_frame(8'h12, good_par(8'h12), 1'b1);
    n_checks++; if (popped_q.size() != 1 || popped_q[0] !== 8'h12)
      $display("FAIL tmo_next_frame: got %0d items want one 12", popped_q.size()); else n_pass++;
    n_checks++; if (n_ferr - ferr0 != 1) $display("FAIL tmo_ferr_once: got %0d want 1", n_ferr - ferr0); else n_pass++;
  endtask

  task automatic test_overflow();
    int            ovf0 = n_ovf;
    int            exp_ovf = 0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] d;
    data_ready = 1'b0;
    popped_q.delete();
    for (int k = 1; k <= DEPTH + 1; k++) begin
      d = DB'(k);
      if (exp_q.size() < DEPTH) exp_q.push_back(d); else exp_ovf++;
      send_frame(d, good_par(d), 1'b1);
      n_checks++; if (n_ovf - ovf0 != exp_ovf)
        $display("FAIL ovf_count_frame%0d: got %0d want %0d", k, n_ovf - ovf0, exp_ovf); else n_pass++;
    end
    @(negedge ck);
    n_checks++; if (data_valid !== 1'b1 || data_out !== exp_q[0])
      $display("FAIL ovf_head: got %h/%b want %h/1", data_out, data_valid, exp_q[0]); else n_pass++;
    wait_cyc(5);
    @(negedge ck);
    n_checks++; if (data_out !== exp_q[0]) $display("FAIL ovf_head_stable: got %h want %h", data_out, exp_q[0]); else n_pass++;
    @(posedge ck); #1;
    data_ready = 1'b1;
    wait_cyc(DEPTH + 6);
    n_checks++; if (popped_q.size() != exp_q.size())
      $display("FAIL ovf_pop_count: got %0d want %0d", popped_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < popped_q.size(); i++) begin
      n_checks++; if (popped_q[i] !== exp_q[i])
        $display("FAIL ovf_pop_order%0d: got %h want %h", i, popped_q[i], exp_q[i]); else n_pass++;
    end
    @(negedge ck);
    n_checks++; if (data_valid !== 1'b0 || data_out !== '0)
      $display("FAIL ovf_drained: got %h/%b want 0/0", data_out, data_valid); else n_pass++;
  endtask

  task automatic test_random();
    int            perr0 = n_perr, ferr0 = n_ferr, ovf0 = n_ovf;
    int            exp_perr = 0, exp_ferr = 0, kind;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] d;
    logic          p, st;
    data_ready = 1'b1;
    popped_q.delete();
    for (int k = 0; k < 24; k++) begin
      d    = DB'($urandom);
      kind = $urandom_range(0, 9);
      p    = good_par(d);
      st   = 1'b1;
      if (kind <= 1 || kind == 4) p = ~p;
      if (kind == 2 || kind == 3 || kind == 4) st = 1'b0;
      if (p != good_par(d)) exp_perr++;
      if (!st) exp_ferr++;
      if (p == good_par(d) && st) exp_q.push_back(d);
      send_frame(d, p, st);
    end
    n_checks++; if (popped_q.size() != exp_q.size())
      $display("FAIL rand_count: got %0d want %0d", popped_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < popped_q.size(); i++) begin
      n_checks++; if (popped_q[i] !== exp_q[i])
        $display("FAIL rand_data%0d: got %h want %h", i, popped_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (n_perr - perr0 != exp_perr) $display("FAIL rand_perr: got %0d want %0d", n_perr - perr0, exp_perr); else n_pass++;
    n_checks++; if (n_ferr - ferr0 != exp_ferr) $display("FAIL rand_ferr: got %0d want %0d", n_ferr - ferr0, exp_ferr); else n_pass++;
    n_checks++; if (n_ovf - ovf0 != 0) $display("FAIL rand_ovf: got %0d want 0", n_ovf - ovf0); else n_pass++;
  endtask

  task automatic test_glitch();
    int            busy0 = busy_hi, perr0 = n_perr, ferr0 = n_ferr;
    logic [DB-1:0] d;
    data_ready = 1'b1;
    popped_q.delete();
    sda = 1'b0;
    wait_cyc(2);
    scl = 1'b0;
    wait_cyc(FL - 1);
    scl = 1'b1;
    wait_cyc(20);
    sda = 1'b1;
    wait_cyc(10);
    n_checks++; if (busy_hi != busy0) $display("FAIL glitch_busy: got %0d busy cycles want 0", busy_hi - busy0); else n_pass++;
    n_checks++; if (n_perr - perr0 + n_ferr - ferr0 != 0)
      $display("FAIL glitch_err: got %0d want 0", n_perr - perr0 + n_ferr - ferr0); else n_pass++;
    d = DB'($urandom);
    send_frame(d, good_par(d), 1'b1);
    n_checks++; if (popped_q.size() != 1 || popped_q[0] !== d)
      $display("FAIL glitch_next_frame: got %0d items want one %h", popped_q.size(), d); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int            perr0 = n_perr, ferr0 = n_ferr, ovf0 = n_ovf;
    logic [DB-1:0] d;
    data_ready = 1'b0;
    d = DB'($urandom);
    send_frame(d, good_par(d), 1'b1);
    @(negedge ck);
    n_checks++; if (data_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", data_valid); else n_pass++;
    send_bits(mk_frame(DB'($urandom), 1'b0, 1'b1), 4);
    sda = 1'b1;
    reset = 1'b0;
    wait_cyc(3);
    @(negedge ck);
    n_checks++; if ({data_valid, parity_err, frame_err, overflow, busy} !== 5'b0 || data_out !== '0)
      $display("FAIL rst_mid_outputs: got %b/%h want 0/0", {data_valid, parity_err, frame_err, overflow, busy}, data_out); else n_pass++;
    @(posedge ck); #1;
    reset = 1'b1;
    wait_cyc(20);
    @(negedge ck);
    n_checks++; if (data_valid !== 1'b0) $display("FAIL rst_buffer_empty: got %b want 0", data_valid); else n_pass++;
    n_checks++; if (n_perr - perr0 + n_ferr - ferr0 + n_ovf - ovf0 != 0)
      $display("FAIL rst_no_err: got %0d want 0", n_perr - perr0 + n_ferr - ferr0 + n_ovf - ovf0); else n_pass++;
    data_ready = 1'b1;
    popped_q.delete();
    d = DB'($urandom);
    send_frame(d, good_par(d), 1'b1);
    n_checks++; if (popped_q.size() != 1 || popped_q[0] !== d)
      $display("FAIL rst_next_frame: got %0d items want one %h", popped_q.size(), d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_overflow();
    test_random();
    test_glitch();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
